bus_bridge: RTL

- Sits directly downstream of the CPU's Bus_* interface and is its only load/store consumer.
- Decodes each access to either the data RAM or a small peripheral space: 7-segment display, LEDs, switches, buttons and a free-running timer.
- Returns read data combinationally so single-cycle loads complete in the same cycle.
- Owns all peripheral state: display scanning, input synchronisers and the timer.

---
 rtl/bridge_pkg.sv | 25 ++
 rtl/bus_bridge_if.sv | 11 +
 rtl/bus_bridge_seg_scan.sv | 56 +++++
 rtl/bus_bridge.sv | 114 +++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared constants for the CPU bus bridge: peripheral base, register offsets
// and the active-low hex-to-7-segment table.
package bridge_pkg;

  // Upper 20 address bits that select the peripheral page
  localparam logic [19:0] PERIPH_BASE = 20'hFFFFF;

  // Peripheral register offsets within the page
  localparam logic [11:0] OFF_DIG   = 12'h000;
  localparam logic [11:0] OFF_TIMER = 12'h020;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;
  localparam logic [11:0] OFF_BTN   = 12'h078;

  // Segment patterns {DP,g,f,e,d,c,b,a}, active-low, DP always off
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/bus_bridge_if.sv
// CPU load/store bus: address, write strobe, write data and combinational
// read data. The CPU drives the master side, the bridge is the slave.
interface bus_bridge_if;
  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  modport master (output Bus_addr, Bus_wen, Bus_wdata, input Bus_rdata);
  modport slave  (input Bus_addr, Bus_wen, Bus_wdata, output Bus_rdata);
endinterface

// File: rtl/bus_bridge_seg_scan.sv
// 8-digit multiplexed 7-segment scanner. Each digit is lit for SCAN_DIV
// cycles; the enable and segment outputs are registered and always reflect
// the digit index that is current after the edge.
module seg_scan
  import bridge_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] dig,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt_reg;
  logic [2:0]    idx_reg;
  logic [7:0]    dig_en_reg;
  logic [7:0]    dig_seg_reg;

  logic          wrap;
  logic [2:0]    idx_next;
  logic [3:0]    nibs [8];

  // Split the display word into per-digit nibbles
  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    assign nibs[gi] = dig[4*gi +: 4];
  end

  assign wrap     = (scan_cnt_reg == CNT_MAX);
  assign idx_next = wrap ? idx_reg + 3'd1 : idx_reg;

  // Advance the dwell counter and digit index; outputs track the next index
  // so they change on the same edge as the index, and a fresh DIG value is
  // picked up one edge after it is written.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      scan_cnt_reg <= '0;
      idx_reg      <= 3'd0;
      dig_en_reg   <= 8'hFE;
      dig_seg_reg  <= 8'hC0;
    end else begin
      scan_cnt_reg <= wrap ? '0 : scan_cnt_reg + CW'(1);
      idx_reg      <= idx_next;
      dig_en_reg   <= ~(8'b1 << idx_next);
      dig_seg_reg  <= hex_to_seg(nibs[idx_next]);
    end
  end

  assign dig_en  = dig_en_reg;
  assign dig_seg = dig_seg_reg;

endmodule

// File: rtl/bus_bridge.sv
// CPU bus bridge: decodes each access to DRAM or the peripheral page and
// owns all peripheral state (display, LEDs, input synchronisers, timer).
// Optional feature macro: BRIDGE_TIMER_EN builds the free-running timer at
// offset 0x020; without it that offset reads 0 and ignores writes.
module bus_bridge
  import bridge_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DRAM_AW  = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  bus_bridge_if.slave        bus,
  output logic [DRAM_AW-1:0] dram_adr,
  output logic               dram_we,
  output logic [31:0]        dram_wdin,
  input  logic [31:0]        dram_rdo,
  input  logic [23:0]        sw,
  input  logic [4:0]         button,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  logic        periph;
  logic [11:0] off;
  logic        pwr;
  logic [31:0] periph_rdata;

  logic [31:0] dig_reg;
  logic [23:0] led_reg;
  logic [23:0] sw_meta_reg;
  logic [23:0] sw_sync_reg;
  logic [4:0]  btn_meta_reg;
  logic [4:0]  btn_sync_reg;

  assign periph = (bus.Bus_addr[31:12] == PERIPH_BASE);
  assign off    = bus.Bus_addr[11:0];
  assign pwr    = bus.Bus_wen & periph;

  assign dram_adr  = bus.Bus_addr[DRAM_AW+1:2];
  assign dram_we   = bus.Bus_wen & ~periph;
  assign dram_wdin = bus.Bus_wdata;

  // Writable peripheral registers; unknown offsets are silently dropped
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      dig_reg <= '0;
      led_reg <= '0;
    end else if (pwr) begin
      if (off == OFF_DIG) dig_reg <= bus.Bus_wdata;
      if (off == OFF_LED) led_reg <= bus.Bus_wdata[23:0];
    end
  end

  // Two-stage synchronisers for the asynchronous switch and button inputs
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      btn_meta_reg <= '0;
      btn_sync_reg <= '0;
    end else begin
      sw_meta_reg  <= sw;
      sw_sync_reg  <= sw_meta_reg;
      btn_meta_reg <= button;
      btn_sync_reg <= btn_meta_reg;
    end
  end

`ifdef BRIDGE_TIMER_EN
  logic [31:0] timer_reg;

  // Free-running timer; a bus write overrides the increment for that cycle
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      timer_reg <= '0;
    end else if (pwr && off == OFF_TIMER) begin
      timer_reg <= bus.Bus_wdata;
    end else begin
      timer_reg <= timer_reg + 32'd1;
    end
  end
`endif

  // Peripheral read mux, zero-wait-state
  always_comb begin
    periph_rdata = '0;
    case (off)
      OFF_DIG:   periph_rdata = dig_reg;
`ifdef BRIDGE_TIMER_EN
      OFF_TIMER: periph_rdata = timer_reg;
`endif
      OFF_LED:   periph_rdata = {8'h00, led_reg};
      OFF_SW:    periph_rdata = {8'h00, sw_sync_reg};
      OFF_BTN:   periph_rdata = {27'h0, btn_sync_reg};
      default:   periph_rdata = '0;
    endcase
  end

  assign bus.Bus_rdata = periph ? periph_rdata : dram_rdo;
  assign led           = led_reg;

  seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .dig     (dig_reg),
    .dig_en  (dig_en),
    .dig_seg (dig_seg)
  );

endmodule
